// File: rtl/cpu_mem_responder_if.sv
// Host-side handshakes of the memory responder: preload stream, run control
// and the post-halt dump stream.
interface cpu_mem_responder_if;
    logic        start;
    logic        load_valid;
    logic        load_ready;
    logic        load_sel;
    logic [15:0] load_addr;
    logic [63:0] load_data;
    logic        dump_valid;
    logic        dump_ready;
    logic [15:0] dump_addr;
    logic [63:0] dump_data;
    logic        done;

    modport master (
        output start, load_valid, load_sel, load_addr, load_data, dump_ready,
        input  load_ready, dump_valid, dump_addr, dump_data, done
    );

    modport slave (
        input  start, load_valid, load_sel, load_addr, load_data, dump_ready,
        output load_ready, dump_valid, dump_addr, dump_data, done
    );
endinterface

// File: rtl/cpu_mem_responder.sv
// Instruction/data memory model for the pipelined core, including the
// preload -> run -> dump lifecycle that holds the core in reset around a run.
module cpu_mem_responder #(
    parameter int IMEM_DEPTH = 256,
    parameter int DMEM_DEPTH = 256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pc,
    output logic [31:0] inst,
    input  logic [63:0] mem_addr,
    input  logic        mem_rw,
    inout  wire  [63:0] mem_data,
    input  logic        halt,
    output logic        cpu_rst,
    cpu_mem_responder_if.slave host
);
    localparam int IW = $clog2(IMEM_DEPTH);
    localparam int DW = $clog2(DMEM_DEPTH);
    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic [1:0] {S_LOAD, S_RUN, S_DUMP, S_DONE} state_t;

    state_t state, nxt;
    logic [DW-1:0] ptr;
    logic [31:0] imem [IMEM_DEPTH];
    logic [63:0] dmem [DMEM_DEPTH];

    logic [IW-1:0] iidx, lidx_i;
    logic [DW-1:0] didx, lidx_d;
    logic load_ready_c, dump_valid_c, done_c;
    logic [63:0] rd_data;

    // Upper address bits are discarded on purpose, so every index wraps.
    assign iidx   = pc[IW+1:2];
    assign didx   = mem_addr[DW+2:3];
    assign lidx_i = host.load_addr[IW-1:0];
    assign lidx_d = host.load_addr[DW-1:0];

    wire unused_addr_bits = ^{pc, mem_addr, host.load_addr};

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_LOAD;
            ptr   <= '0;
        end else begin
            state <= nxt;
            if (dump_valid_c && host.dump_ready) ptr <= ptr + 1'b1;
        end
    end

    always_comb begin
        nxt          = state;
        cpu_rst      = 1'b1;
        load_ready_c = 1'b0;
        dump_valid_c = 1'b0;
        done_c       = 1'b0;
        case (state)
            S_LOAD: begin
                load_ready_c = 1'b1;
                if (host.start) nxt = S_RUN;
            end
            S_RUN: begin
                cpu_rst = 1'b0;
                if (halt) nxt = S_DUMP;
            end
            S_DUMP: begin
                dump_valid_c = 1'b1;
                if (host.dump_ready && (&ptr)) nxt = S_DONE;
            end
            S_DONE:  done_c = 1'b1;
            default: nxt = S_LOAD;
        endcase
    end

    // Arrays carry no reset so preloaded and run-time contents survive rst.
    always_ff @(posedge clk) begin
        if (!rst && state == S_LOAD && host.load_valid) begin
            if (host.load_sel) dmem[lidx_d] <= host.load_data;
            else               imem[lidx_i] <= host.load_data[31:0];
        end
        if (!rst && state == S_RUN && mem_rw) dmem[didx] <= mem_data;
    end

    assign rd_data  = dmem[didx];
    assign inst     = (state == S_RUN) ? imem[iidx] : NOP;
    assign mem_data = (state == S_RUN && !mem_rw) ? rd_data : 64'bz;

    assign host.load_ready = load_ready_c;
    assign host.dump_valid = dump_valid_c;
    assign host.dump_addr  = 16'(ptr);
    assign host.dump_data  = dmem[ptr];
    assign host.done       = done_c;
endmodule

// File: tb/tb_cpu_mem_responder.sv
// Directed bench for cpu_mem_responder: preload, run-time fetch/read/write,
// halt-triggered dump with backpressure, and reset abandoning a dump.
module tb_cpu_mem_responder;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] pc = '0;
    logic [31:0] inst;
    logic [63:0] mem_addr = '0;
    logic        mem_rw = 1'b0;
    wire  [63:0] mem_data;
    logic        halt = 1'b0;
    logic        cpu_rst;
    logic        tb_en = 1'b1;
    logic [63:0] tb_val = '0;

    logic [63:0] model [256];
    int n_tests = 0;
    int n_fail = 0;

    cpu_mem_responder_if host();

    cpu_mem_responder #(.IMEM_DEPTH(256), .DMEM_DEPTH(256)) dut (
        .clk(clk), .rst(rst), .pc(pc), .inst(inst), .mem_addr(mem_addr),
        .mem_rw(mem_rw), .mem_data(mem_data), .halt(halt), .cpu_rst(cpu_rst),
        .host(host)
    );

    // Bench drives the bus while writing and whenever the responder must be
    // quiet; a zero pattern makes any stray responder drive visible.
    assign mem_data = tb_en ? tb_val : 64'bz;

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_beat(input logic sel, input logic [15:0] a, input logic [63:0] d);
        host.load_valid = 1'b1; host.load_sel = sel; host.load_addr = a; host.load_data = d;
        tick();
        host.load_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1; tick(); rst = 1'b0;
    endtask

    task automatic test_reset();
        host.start = 0; host.load_valid = 0; host.load_sel = 0; host.load_addr = '0;
        host.load_data = '0; host.dump_ready = 0;
        tb_en = 1; tb_val = '0;
        tick(); tick(); rst = 1'b0; #1;
        n_tests++; if (cpu_rst !== 1'b1) begin n_fail++; $display("FAIL reset_cpu_rst got %b want 1", cpu_rst); end
        n_tests++; if (host.load_ready !== 1'b1) begin n_fail++; $display("FAIL reset_load_ready got %b want 1", host.load_ready); end
        n_tests++; if (host.dump_valid !== 1'b0) begin n_fail++; $display("FAIL reset_dump_valid got %b want 0", host.dump_valid); end
        n_tests++; if (host.dump_addr !== 16'd0) begin n_fail++; $display("FAIL reset_dump_addr got %h want 0", host.dump_addr); end
        n_tests++; if (host.done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b want 0", host.done); end
        n_tests++; if (inst !== 32'h13) begin n_fail++; $display("FAIL reset_inst got %h want 00000013", inst); end
        n_tests++; if (mem_data !== 64'd0) begin n_fail++; $display("FAIL reset_bus_quiet got %h want 0", mem_data); end
        // halt must be ignored while loading
        halt = 1'b1; tick(); halt = 1'b0;
        n_tests++; if (host.load_ready !== 1'b1) begin n_fail++; $display("FAIL load_ignores_halt got %b want 1", host.load_ready); end
    endtask

    task automatic test_load();
        for (int i = 0; i < 256; i++) begin
            model[i] = 64'hC0DE_0000_0000_0000 | 64'(i);
            load_beat(1'b1, 16'(i), model[i]);
        end
        model[3] = 64'hDEADBEEF_00000001; load_beat(1'b1, 16'd3, model[3]);
        model[4] = 64'hFFFF0000_0000FFFF; load_beat(1'b1, 16'h0104, model[4]);
        load_beat(1'b0, 16'd0, 64'h13);
        load_beat(1'b0, 16'd1, 64'hFFFF_FFFF_00A0_0093);
        load_beat(1'b0, 16'h0105, 64'h1234_5678);
        n_tests++; if (inst !== 32'h13) begin n_fail++; $display("FAIL load_inst_nop got %h want 00000013", inst); end
    endtask

    task automatic test_start_run();
        host.start = 1'b1;
        host.load_valid = 1'b1; host.load_sel = 1'b1; host.load_addr = 16'd7; host.load_data = 64'h77;
        model[7] = 64'h77;
        #1;
        n_tests++; if (cpu_rst !== 1'b1) begin n_fail++; $display("FAIL start_cycle_cpu_rst got %b want 1", cpu_rst); end
        tick();
        host.start = 1'b0; host.load_valid = 1'b0;
        n_tests++; if (cpu_rst !== 1'b0) begin n_fail++; $display("FAIL run_cpu_rst got %b want 0", cpu_rst); end
        n_tests++; if (host.load_ready !== 1'b0) begin n_fail++; $display("FAIL run_load_ready got %b want 0", host.load_ready); end
        tb_en = 0; pc = 32'h0; mem_addr = 64'h18; mem_rw = 0; #1;
        n_tests++; if (inst !== 32'h13) begin n_fail++; $display("FAIL fetch_pc0 got %h want 00000013", inst); end
        n_tests++; if (mem_data !== 64'hDEADBEEF_00000001) begin n_fail++; $display("FAIL read_0x18 got %h want deadbeef00000001", mem_data); end
        pc = 32'h14; mem_addr = 64'h38; #1;
        n_tests++; if (inst !== 32'h1234_5678) begin n_fail++; $display("FAIL fetch_wrapped_load got %h want 12345678", inst); end
        n_tests++; if (mem_data !== 64'h77) begin n_fail++; $display("FAIL load_with_start got %h want 77", mem_data); end
        pc = 32'h407; #1;
        n_tests++; if (inst !== 32'h00A0_0093) begin n_fail++; $display("FAIL fetch_wrap_align got %h want 00a00093", inst); end
    endtask

    task automatic test_write_read();
        mem_rw = 1; mem_addr = 64'h20; tb_en = 1; tb_val = 64'h1234; #1;
        n_tests++; if (mem_data !== 64'h1234) begin n_fail++; $display("FAIL write_bus_hiz got %h want 1234", mem_data); end
        tick(); model[4] = 64'h1234;
        mem_rw = 0; tb_en = 0; #1;
        n_tests++; if (mem_data !== 64'h1234) begin n_fail++; $display("FAIL write_readback got %h want 1234", mem_data); end
    endtask

    task automatic test_wrap();
        mem_rw = 1; mem_addr = 64'h805; tb_en = 1; tb_val = 64'hAA;
        tick(); model[0] = 64'hAA;
        mem_rw = 0; tb_en = 0; mem_addr = 64'h0; #1;
        n_tests++; if (mem_data !== 64'hAA) begin n_fail++; $display("FAIL wrap_read_0 got %h want aa", mem_data); end
        mem_addr = 64'h28; #1;
        n_tests++; if (mem_data !== model[5]) begin n_fail++; $display("FAIL untouched_idx5 got %h want %h", mem_data, model[5]); end
    endtask

    task automatic test_halt_dump();
        halt = 1; mem_rw = 1; mem_addr = 64'h0; tb_en = 1; tb_val = 64'h55; host.dump_ready = 1;
        tick(); model[0] = 64'h55;
        halt = 0; mem_rw = 0; tb_val = '0; #1;
        n_tests++; if (cpu_rst !== 1'b1) begin n_fail++; $display("FAIL dump_cpu_rst got %b want 1", cpu_rst); end
        n_tests++; if (inst !== 32'h13) begin n_fail++; $display("FAIL dump_inst got %h want 00000013", inst); end
        n_tests++; if (mem_data !== 64'd0) begin n_fail++; $display("FAIL dump_bus_quiet got %h want 0", mem_data); end
        n_tests++; if (host.dump_data !== 64'h55) begin n_fail++; $display("FAIL first_beat_data got %h want 55", host.dump_data); end
        for (int i = 0; i < 256; i++) begin
            n_tests++; if (host.dump_valid !== 1'b1 || host.dump_addr !== 16'(i)) begin
                n_fail++; $display("FAIL dump_beat_addr got v=%b a=%0d want v=1 a=%0d", host.dump_valid, host.dump_addr, i); end
            n_tests++; if (host.dump_data !== model[i]) begin
                n_fail++; $display("FAIL dump_beat_data at %0d got %h want %h", i, host.dump_data, model[i]); end
            tick();
        end
        n_tests++; if (host.done !== 1'b1 || host.dump_valid !== 1'b0) begin
            n_fail++; $display("FAIL done_after_256 got done=%b v=%b want done=1 v=0", host.done, host.dump_valid); end
        tick(); tick(); tick();
        n_tests++; if (host.done !== 1'b1 || cpu_rst !== 1'b1) begin
            n_fail++; $display("FAIL done_held got done=%b cpu_rst=%b want 1 1", host.done, cpu_rst); end
    endtask

    task automatic test_backpressure();
        logic [3:0] rdy;
        int exp_a [5];
        rdy = 4'b1001;
        exp_a = '{0, 1, 1, 1, 2};
        do_reset();
        host.dump_ready = 0;
        host.start = 1; tick(); host.start = 0;
        halt = 1; tick(); halt = 0;
        for (int k = 0; k < 5; k++) begin
            host.dump_ready = (k < 4) ? rdy[3-k] : 1'b1; #1;
            n_tests++; if (host.dump_addr !== 16'(exp_a[k]) || host.dump_data !== model[exp_a[k]]) begin
                n_fail++; $display("FAIL backpressure step %0d got a=%0d d=%h want a=%0d d=%h",
                                   k, host.dump_addr, host.dump_data, exp_a[k], model[exp_a[k]]); end
            tick();
        end
    endtask

    task automatic test_reset_mid_dump();
        for (int k = 0; k < 7; k++) tick();
        n_tests++; if (host.dump_addr !== 16'd10) begin n_fail++; $display("FAIL reach_beat10 got %0d want 10", host.dump_addr); end
        rst = 1; tick(); rst = 0;
        n_tests++; if (host.dump_valid !== 1'b0 || host.load_ready !== 1'b1 || cpu_rst !== 1'b1) begin
            n_fail++; $display("FAIL rst_mid_dump got v=%b lr=%b cr=%b want 0 1 1", host.dump_valid, host.load_ready, cpu_rst); end
        n_tests++; if (host.dump_addr !== 16'd0) begin n_fail++; $display("FAIL rst_ptr got %0d want 0", host.dump_addr); end
        host.start = 1; tick(); host.start = 0;
        tb_en = 0; mem_rw = 0; mem_addr = 64'h0; #1;
        n_tests++; if (mem_data !== 64'h55) begin n_fail++; $display("FAIL retain_idx0 got %h want 55", mem_data); end
        mem_addr = 64'h20; #1;
        n_tests++; if (mem_data !== 64'h1234) begin n_fail++; $display("FAIL retain_idx4 got %h want 1234", mem_data); end
        mem_addr = 64'h18; #1;
        n_tests++; if (mem_data !== 64'hDEADBEEF_00000001) begin n_fail++; $display("FAIL retain_idx3 got %h want deadbeef00000001", mem_data); end
        tb_en = 1; tb_val = '0;
    endtask

    initial begin
        test_reset();
        test_load();
        test_start_run();
        test_write_read();
        test_wrap();
        test_halt_dump();
        test_backpressure();
        test_reset_mid_dump();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
